// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle of the hazard scoreboard: ID-stage operand/destination
// information in, stall/flush controls and performance counters out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] ID_RegRs;
  logic [REG_ADDR_W-1:0] ID_RegRt;
  logic                  ID_UseRs;
  logic                  ID_UseRt;
  logic [REG_ADDR_W-1:0] ID_WriteReg;
  logic                  ID_RegWrite;
  logic                  ID_MemRead;
  logic                  branch;
  logic                  branch_taken;
  logic                  mem_stall_i;

  logic                  IF_Flush;
  logic                  ID_Flush;
  logic                  PC_Write;
  logic                  IF_ID_PipeRegWrite;
  logic [1:0]            hazard_cause;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // The pipeline drives the ID-stage view and consumes the controls.
  modport master (
    output ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_WriteReg, ID_RegWrite,
           ID_MemRead, branch, branch_taken, mem_stall_i,
    input  IF_Flush, ID_Flush, PC_Write, IF_ID_PipeRegWrite, hazard_cause,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_WriteReg, ID_RegWrite,
           ID_MemRead, branch, branch_taken, mem_stall_i,
    output IF_Flush, ID_Flush, PC_Write, IF_ID_PipeRegWrite, hazard_cause,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline built around a
// per-register countdown of cycles until each in-flight result is forwardable.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  hazard_scoreboard_unit_if.slave  hz
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int CW   = $clog2(LOAD_LAT + 1);

  localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OP   = 2'd1,
    CAUSE_BR   = 2'd2,
    CAUSE_MEM  = 2'd3
  } cause_e;

  logic [CW-1:0]    cnt [NREG];
  logic [CW-1:0]    cnt_rs, cnt_rt;
  logic             rs_ready, rt_ready, op_stall, issue;
  logic [CW-1:0]    dest_cnt;
  cause_e           cause;
  logic             if_flush, id_flush, pc_write, ifid_we;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign cnt_rs = cnt[hz.ID_RegRs];
  assign cnt_rt = cnt[hz.ID_RegRt];

  // Branches compare in ID, so they need the value one cycle earlier than an
  // EX consumer, which can still pick it up from the forwarding network.
  assign rs_ready = !hz.ID_UseRs || (hz.ID_RegRs == '0) ||
                    (hz.branch ? (cnt_rs == '0) : (cnt_rs <= ONE_CNT));
  assign rt_ready = !hz.ID_UseRt || (hz.ID_RegRt == '0) ||
                    (hz.branch ? (cnt_rt == '0) : (cnt_rt <= ONE_CNT));
  assign op_stall = !(rs_ready && rt_ready);
  assign issue    = !hz.mem_stall_i && !op_stall;
  assign dest_cnt = hz.ID_MemRead ? LOAD_CNT : ALU_CNT;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the if/else chain leaves a signal unassigned and infers a latch.
    cause    = CAUSE_NONE;
    if_flush = 1'b0;
    id_flush = 1'b0;
    pc_write = 1'b1;
    ifid_we  = 1'b1;
    if (rst_i) begin
      if (hz.mem_stall_i) begin
        cause    = CAUSE_MEM;
        pc_write = 1'b0;
        ifid_we  = 1'b0;
      end else if (op_stall) begin
        cause    = hz.branch ? CAUSE_BR : CAUSE_OP;
        pc_write = 1'b0;
        ifid_we  = 1'b0;
        id_flush = 1'b1;
      end else if (hz.branch && hz.branch_taken) begin
        if_flush = 1'b1;
      end
    end
  end

  // NOTE: the scoreboard is an array of flops, not a RAM, and every entry must
  // be cleared on reset so no stale pending result survives into the next run.
  // Sequential state uses non-blocking assignments so all entries update from
  // the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!hz.mem_stall_i) begin
      // Entry 0 is left untouched after reset, so it reads as "ready" forever.
      for (int r = 1; r < NREG; r++) begin
        if (issue && hz.ID_RegWrite && (hz.ID_WriteReg == REG_ADDR_W'(r)))
          cnt[r] <= dest_cnt;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (((cause == CAUSE_OP) || (cause == CAUSE_BR)) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (if_flush && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.IF_Flush           = if_flush;
  assign hz.ID_Flush           = id_flush;
  assign hz.PC_Write           = pc_write;
  assign hz.IF_ID_PipeRegWrite = ifid_we;
  assign hz.hazard_cause       = cause;
  assign hz.stall_cnt          = stall_q;
  assign hz.flush_cnt          = flush_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: two instances (default latencies, and ALU=2/LOAD=4 with
// 2-bit counters) run the same stimulus against a ready-time reference model.
module tb_hazard_scoreboard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) if_a ();
  hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  if_b ();

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .ALU_LAT(1), .LOAD_LAT(2), .CNT_W(16)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (if_a.slave)
  );

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .ALU_LAT(2), .LOAD_LAT(4), .CNT_W(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (if_b.slave)
  );

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       urs, urt, rw, mr, br, bt, ms, rst_n;
  } stim_t;

  typedef struct {
    logic [5:0] ctl;  // {IF_Flush, ID_Flush, PC_Write, IF_ID_PipeRegWrite, cause}
    int         sc;
    int         fc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: a virtual clock that advances on every unfrozen edge,
  // and the virtual time at which each register's result becomes forwardable.
  int vt       [2];
  int ready_at [2][32];
  int alu_lat  [2] = '{1, 2};
  int load_lat [2] = '{2, 4};
  int cnt_max  [2] = '{65535, 3};
  int scnt     [2];
  int fcnt     [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  function automatic int remaining(input int k, input logic [4:0] r);
    int d;
    if (r == 5'd0) return 0;
    d = ready_at[k][r] - vt[k];
    return (d > 0) ? d : 0;
  endfunction

  task automatic model_step(input int k, input stim_t s);
    logic       op;
    logic [5:0] ctl;
    exp_t       e;
    op = 1'b0;
    if (s.urs && s.rs != 0 && (s.br ? remaining(k, s.rs) > 0 : remaining(k, s.rs) > 1)) op = 1'b1;
    if (s.urt && s.rt != 0 && (s.br ? remaining(k, s.rt) > 0 : remaining(k, s.rt) > 1)) op = 1'b1;

    if (!s.rst_n)          ctl = 6'b0011_00;
    else if (s.ms)         ctl = 6'b0000_11;
    else if (op)           ctl = s.br ? 6'b0100_10 : 6'b0100_01;
    else if (s.br && s.bt) ctl = 6'b1011_00;
    else                   ctl = 6'b0011_00;

    e.ctl = ctl;
    e.sc  = scnt[k];
    e.fc  = fcnt[k];
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);

    if (!s.rst_n) begin
      vt[k]   = 0;
      scnt[k] = 0;
      fcnt[k] = 0;
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
    end else begin
      if ((ctl[1:0] == 2'd1 || ctl[1:0] == 2'd2) && scnt[k] < cnt_max[k]) scnt[k]++;
      if (ctl[5] && fcnt[k] < cnt_max[k]) fcnt[k]++;
      if (!s.ms) begin
        vt[k]++;
        if (!op && s.rw && s.wr != 0)
          ready_at[k][s.wr] = vt[k] + (s.mr ? load_lat[k] : alu_lat[k]);
      end
    end
  endtask

  task automatic drive(input stim_t s);
    if_a.ID_RegRs = s.rs;  if_b.ID_RegRs = s.rs;
    if_a.ID_RegRt = s.rt;  if_b.ID_RegRt = s.rt;
    if_a.ID_UseRs = s.urs; if_b.ID_UseRs = s.urs;
    if_a.ID_UseRt = s.urt; if_b.ID_UseRt = s.urt;
    if_a.ID_WriteReg = s.wr; if_b.ID_WriteReg = s.wr;
    if_a.ID_RegWrite = s.rw; if_b.ID_RegWrite = s.rw;
    if_a.ID_MemRead  = s.mr; if_b.ID_MemRead  = s.mr;
    if_a.branch       = s.br; if_b.branch       = s.br;
    if_a.branch_taken = s.bt; if_b.branch_taken = s.bt;
    if_a.mem_stall_i  = s.ms; if_b.mem_stall_i  = s.ms;
    rst = s.rst_n;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cycle++;
    drive(s);
    model_step(0, s);
    model_step(1, s);
  endtask

  function automatic stim_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                               input logic urt, input logic [4:0] wr, input logic rw,
                               input logic mr, input logic br, input logic bt,
                               input logic ms, input logic rst_n);
    stim_t s;
    s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt; s.wr = wr; s.rw = rw;
    s.mr = mr; s.br = br; s.bt = bt; s.ms = ms; s.rst_n = rst_n;
    return s;
  endfunction

  // Shorthands: nop, ALU write, load, non-branch read, taken branch.
  function automatic stim_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic stim_t alu(input logic [4:0] d);
    return mk(0, 0, 0, 0, d, 1, 0, 0, 0, 0, 1);
  endfunction
  function automatic stim_t ld(input logic [4:0] d);
    return mk(0, 0, 0, 0, d, 1, 1, 0, 0, 0, 1);
  endfunction
  function automatic stim_t use_r(input logic [4:0] a);
    return mk(a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic stim_t beq(input logic [4:0] a, input logic [4:0] b);
    return mk(a, 1, b, 1, 0, 0, 0, 1, 1, 0, 1);
  endfunction

  // Monitor: every cycle the DUT presents a fresh control word; compare it
  // against the oldest pending expectation of each instance.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_ctl", {26'd0, if_a.IF_Flush, if_a.ID_Flush, if_a.PC_Write,
                      if_a.IF_ID_PipeRegWrite, if_a.hazard_cause}, {26'd0, e.ctl});
      check("a_stall_cnt", {16'd0, if_a.stall_cnt}, e.sc);
      check("a_flush_cnt", {16'd0, if_a.flush_cnt}, e.fc);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_ctl", {26'd0, if_b.IF_Flush, if_b.ID_Flush, if_b.PC_Write,
                      if_b.IF_ID_PipeRegWrite, if_b.hazard_cause}, {26'd0, e.ctl});
      check("b_stall_cnt", {30'd0, if_b.stall_cnt}, e.sc);
      check("b_flush_cnt", {30'd0, if_b.flush_cnt}, e.fc);
    end
  end

  initial begin
    stim_t s;
    for (int k = 0; k < 2; k++) begin
      vt[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
    end
    s = nop();
    s.rst_n = 1'b0;
    drive(s);
    repeat (2) step(s);

    // ALU producer then non-branch consumer.
    step(alu(3)); step(use_r(3)); step(nop()); step(nop()); step(nop());
    // Load producer then consumer held in ID while stalled.
    step(ld(3)); repeat (4) step(use_r(3)); step(nop());
    // Load and ALU producers feeding an ID-stage taken branch.
    step(ld(3)); repeat (4) step(beq(3, 4)); step(nop()); step(nop());
    step(alu(3)); repeat (4) step(beq(4, 3)); step(nop()); step(nop());
    // Long load latency on the second instance.
    step(ld(5)); repeat (5) step(use_r(5)); step(nop()); step(nop());
    // Writes to $0 never create a dependency.
    step(ld(0)); step(mk(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1)); step(use_r(0)); step(nop());
    // Memory freeze between load and dependent read.
    step(ld(3));
    s = use_r(3); s.ms = 1'b1;
    repeat (3) step(s);
    repeat (4) step(use_r(3)); step(nop());
    // Reset asserted for one edge in the middle of a stall.
    step(ld(3)); step(beq(3, 3));
    s = beq(3, 3); s.rst_n = 1'b0;
    step(s);
    step(beq(3, 3)); step(nop());
    // Enough branch stalls in a row to saturate the 2-bit counters.
    step(ld(6)); repeat (6) step(beq(6, 6)); step(nop());

    // Randomised traffic over a small register window to keep hazards dense.
    for (int i = 0; i < 3000; i++) begin
      s.rs    = 5'($urandom_range(0, 7));
      s.rt    = 5'($urandom_range(0, 7));
      s.wr    = 5'($urandom_range(0, 7));
      s.urs   = 1'($urandom_range(0, 3) != 0);
      s.urt   = 1'($urandom_range(0, 1));
      s.rw    = 1'($urandom_range(0, 3) != 0);
      s.mr    = 1'($urandom_range(0, 2) == 0);
      s.br    = 1'($urandom_range(0, 3) == 0);
      s.bt    = 1'($urandom_range(0, 1));
      s.ms    = 1'($urandom_range(0, 5) == 0);
      s.rst_n = 1'($urandom_range(0, 99) != 0);
      step(s);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised stall/flush controller for the 5-stage MIPS pipeline, successor to the fixed one-cycle load-use detector. It keeps a per-register countdown scoreboard of in-flight results, so loads and ALU ops may have configurable latency. It stalls ID consumers, both ordinary and ID-stage branch, until operands are forwardable. It also flushes IF on a taken branch, freezes the pipe on an external memory stall, and keeps saturating performance counters.

Parameters:
REG_ADDR_W, 5, register address width; scoreboard depth is 2**REG_ADDR_W entries.
ALU_LAT, 1, cycles after issue until an ALU result is forwardable to EX inputs; must be >= 1.
LOAD_LAT, 2, same for loads; must be >= ALU_LAT.
CNT_W, 16, width of the performance counters.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-low reset.
ID_RegRs  in  REG_ADDR_W  rs of the instruction in ID.
ID_RegRt  in  REG_ADDR_W  rt of the instruction in ID.
ID_UseRs  in  1  ID instruction reads rs.
ID_UseRt  in  1  ID instruction reads rt.
ID_WriteReg  in  REG_ADDR_W  destination of the ID instruction.
ID_RegWrite  in  1  ID instruction writes a register.
ID_MemRead  in  1  ID instruction is a load.
branch  in  1  ID instruction is a branch; it compares operands in ID.
branch_taken  in  1  branch in ID resolved taken (valid only when operands are ready).
mem_stall_i  in  1  memory busy; freeze the pipeline.
IF_Flush  out  1  squash IF/ID contents.
ID_Flush  out  1  insert a bubble into ID/EX.
PC_Write  out  1  PC update enable.
IF_ID_PipeRegWrite  out  1  IF/ID write enable.
hazard_cause  out  2  0 none, 1 operand stall (non-branch), 2 branch operand stall, 3 memory stall.
stall_cnt  out  CNT_W  count of operand-stall cycles.
flush_cnt  out  CNT_W  count of IF_Flush cycles.

Behaviour:
- State: cnt[r] for each register r, width clog2(LOAD_LAT+1). cnt[r] is the number of cycles until r's pending result is forwardable to EX. Register 0 is never tracked; cnt[0] is always 0.
- Reset (rst_i=0 at an edge): all cnt[r]=0 and stall_cnt=flush_cnt=0.
- While rst_i=0, outputs are forced to IF_Flush=0, ID_Flush=0, PC_Write=1, IF_ID_PipeRegWrite=1, hazard_cause=0.
- Reset asserted mid-stall clears all pending state; the first cycle after reset shows no stall.
- Readiness per used, nonzero source s:
  - Non-branch: needs cnt[s] <= 1.
  - Branch: needs cnt[s] == 0.
  - An unused or zero source is always ready.
  - op_stall is 1 when any source is not ready.
- Output priority is combinational from current state and inputs:
  1. mem_stall_i: PC_Write=0, IF_ID_PipeRegWrite=0, ID_Flush=0, IF_Flush=0, cause=3.
  2. op_stall: PC_Write=0, IF_ID_PipeRegWrite=0, ID_Flush=1, IF_Flush=0, cause=2 if branch else 1. branch_taken is ignored.
  3. branch & branch_taken: IF_Flush=1, ID_Flush=0, PC_Write=1, IF_ID_PipeRegWrite=1, cause=0.
  4. Otherwise: all enables 1, all flushes 0, cause=0.
- Issue: issue = ~mem_stall_i & ~op_stall.
- Scoreboard update at each edge:
  - If mem_stall_i=1, all cnt hold.
  - Otherwise each nonzero cnt decrements by 1.
  - Then, if issue & ID_RegWrite & ID_WriteReg!=0, cnt[ID_WriteReg] is set to LOAD_LAT if ID_MemRead, else ALU_LAT.
  - Set overrides decrement for the same register on the same edge.
- Resulting stall counts at defaults (producer immediately ahead of consumer):
  - ALU -> non-branch: 0 stalls.
  - Load -> non-branch: 1 stall.
  - ALU -> branch: 1 stall.
  - Load -> branch: 2 stalls.
  - In general: non-branch stalls max(0, LAT-1) cycles; branch stalls LAT cycles.
- Performance counters:
  - stall_cnt increments on each edge with cause 1 or 2.
  - flush_cnt increments on each edge with IF_Flush=1.
  - Both saturate at all-ones.
  - Neither changes during a memory stall, since cause is then 3 and IF_Flush is 0.

Test Plan:
- Defaults: issue add $3 (ALU); next cycle ID uses $3 non-branch -> no stall, PC_Write=1, cause=0.
- lw $3 issued; next ID uses $3 -> exactly 1 cycle PC_Write=0, ID_Flush=1, cause=1, then proceeds; stall_cnt=1.
- lw $3 then beq $3,$4 taken -> 2 stall cycles (cause=2), then IF_Flush=1 for 1 cycle; stall_cnt=2, flush_cnt=1. With add $3 as producer instead -> 1 stall.
- LOAD_LAT=4: lw $5 then use $5 -> 3 stall cycles. Writes to $0 followed by a read of $0 -> never stall.
- lw $3, then mem_stall_i=1 for 3 cycles, then dependent read -> during the freeze PC_Write=0, ID_Flush=0, cause=3, cnt held; afterwards the dependent still stalls 1 cycle.
- Mid-stall rst_i=0 for one edge -> next cycle no stall, counters 0. With CNT_W=2, 5 stall cycles -> stall_cnt=3 (saturated).
